// File: rtl/regfile_pkg.sv
// Shared widths and the queued writeback entry type for the register-file write side.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_entry_queue.sv
// In-order FIFO of pending register-file writes; exposes every slot plus its valid bit
// so the top level can compare all queued destinations against the decoder's read indices.
module wb_entry_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [CNT_W-1:0]         count,
  output logic [PTR_W-1:0]         head_ptr,
  output logic [DEPTH-1:0]         valid_flat,
  output logic [DEPTH*ENTRY_W-1:0] entries_flat
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] tail_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL_COUNT);
  assign do_pop  = pop && (count != '0);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values,
  // which lets a push and a pop in the same cycle see the same count and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count      <= '0;
      valid_flat <= '0;
    end else begin
      if (do_pop) begin
        valid_flat[head_ptr] <= 1'b0;
        head_ptr             <= head_ptr + PTR_ONE;
      end
      if (do_push) begin
        valid_flat[tail_ptr] <= 1'b1;
        tail_ptr             <= tail_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // NOTE: entry storage is not reset; the valid bits and count alone decide what is live,
  // so stale payloads are never observable and the array can map to plain registers or RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail_ptr] <= '{addr: push_addr, data: push_data};
    end
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    entries_flat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      entries_flat[k*ENTRY_W +: ENTRY_W] = mem[k];
    end
  end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Writeback sequencer: arbitrates ALU/load write requests into an in-order queue, issues one
// register-file write per cycle from the queue head, and flags read-after-write hazards.
// Optional macro WB_FORWARD_EN: drive fwd_a_data/fwd_b_data with the youngest matching queued data.
module regfile_wb_sequencer
  import regfile_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  localparam int PTR_W = $clog2(QUEUE_DEPTH),
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_wr_valid,
  output logic              alu_wr_ready,
  input  logic [ADDR_W-1:0] alu_wr_addr,
  input  logic [DATA_W-1:0] alu_wr_data,
  input  logic              mem_wr_valid,
  output logic              mem_wr_ready,
  input  logic [ADDR_W-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic              rf_port_stall,
  output logic              rf_write_register_d,
  output logic [ADDR_W-1:0] rf_register_d,
  output logic [DATA_W-1:0] rf_data_d_in,
  input  logic [ADDR_W-1:0] query_a,
  input  logic [ADDR_W-1:0] query_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [DATA_W-1:0] fwd_a_data,
  output logic [DATA_W-1:0] fwd_b_data,
  output logic [CNT_W-1:0]  pending_count
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

  logic [CNT_W-1:0]               count;
  logic [PTR_W-1:0]               head_ptr;
  logic [QUEUE_DEPTH-1:0]         valid_flat;
  logic [QUEUE_DEPTH*ENTRY_W-1:0] entries_flat;
  wb_entry_t                      entries [QUEUE_DEPTH];
  wb_entry_t                      head_entry;
  logic                           full;
  logic                           empty;
  logic                           push;
  logic [ADDR_W-1:0]              push_addr;
  logic [DATA_W-1:0]              push_data;
  logic                           pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Ready looks only at the stored occupancy, never at this cycle's dequeue.
  assign mem_wr_ready = !reset && !full;
  assign alu_wr_ready = !reset && !full && !mem_wr_valid;

  // Loads win; when a load is presented the ALU is not ready, so at most one source enqueues.
  assign push      = (mem_wr_valid && mem_wr_ready) || (alu_wr_valid && alu_wr_ready);
  assign push_addr = mem_wr_valid ? mem_wr_addr : alu_wr_addr;
  assign push_data = mem_wr_valid ? mem_wr_data : alu_wr_data;
  assign pop       = !empty && !rf_port_stall;

  wb_entry_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_addr    (push_addr),
    .push_data    (push_data),
    .pop          (pop),
    .count        (count),
    .head_ptr     (head_ptr),
    .valid_flat   (valid_flat),
    .entries_flat (entries_flat)
  );

  always_comb begin
    entries = '{default: '0};
    for (int k = 0; k < QUEUE_DEPTH; k++) begin
      entries[k] = wb_entry_t'(entries_flat[k*ENTRY_W +: ENTRY_W]);
    end
  end

  assign head_entry          = entries[head_ptr];
  assign rf_write_register_d = !empty;
  assign rf_register_d       = empty ? '0 : head_entry.addr;
  assign rf_data_d_in        = empty ? '0 : head_entry.data;
  assign pending_count       = count;

  // Walk slots oldest to youngest so the last match seen is the youngest write to that index.
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
`ifdef WB_FORWARD_EN
    fwd_a_data = '0;
    fwd_b_data = '0;
`endif
    for (int k = 0; k < QUEUE_DEPTH; k++) begin
      if (valid_flat[head_ptr + PTR_W'(k)] && entries[head_ptr + PTR_W'(k)].addr == query_a) begin
        hazard_a = 1'b1;
`ifdef WB_FORWARD_EN
        fwd_a_data = entries[head_ptr + PTR_W'(k)].data;
`endif
      end
      if (valid_flat[head_ptr + PTR_W'(k)] && entries[head_ptr + PTR_W'(k)].addr == query_b) begin
        hazard_b = 1'b1;
`ifdef WB_FORWARD_EN
        fwd_b_data = entries[head_ptr + PTR_W'(k)].data;
`endif
      end
    end
  end

`ifndef WB_FORWARD_EN
  assign fwd_a_data = '0;
  assign fwd_b_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Self-checking bench for regfile_wb_sequencer: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the writeback rules.
module tb_regfile_wb_sequencer;
  import regfile_pkg::*;

  localparam int QD    = 4;
  localparam int CNT_W = $clog2(QD + 1);

  logic              clk;
  logic              reset;
  logic              alu_wr_valid, alu_wr_ready;
  logic [ADDR_W-1:0] alu_wr_addr;
  logic [DATA_W-1:0] alu_wr_data;
  logic              mem_wr_valid, mem_wr_ready;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              rf_port_stall;
  logic              rf_write_register_d;
  logic [ADDR_W-1:0] rf_register_d;
  logic [DATA_W-1:0] rf_data_d_in;
  logic [ADDR_W-1:0] query_a, query_b;
  logic              hazard_a, hazard_b;
  logic [DATA_W-1:0] fwd_a_data, fwd_b_data;
  logic [CNT_W-1:0]  pending_count;

  wb_entry_t model_q[$];
  wb_entry_t exp_log[$];
  wb_entry_t dut_log[$];
  int        n_cmp  = 0;
  int        n_fail = 0;

  regfile_wb_sequencer #(.QUEUE_DEPTH(QD)) dut (
    .clk                 (clk),
    .reset               (reset),
    .alu_wr_valid        (alu_wr_valid),
    .alu_wr_ready        (alu_wr_ready),
    .alu_wr_addr         (alu_wr_addr),
    .alu_wr_data         (alu_wr_data),
    .mem_wr_valid        (mem_wr_valid),
    .mem_wr_ready        (mem_wr_ready),
    .mem_wr_addr         (mem_wr_addr),
    .mem_wr_data         (mem_wr_data),
    .rf_port_stall       (rf_port_stall),
    .rf_write_register_d (rf_write_register_d),
    .rf_register_d       (rf_register_d),
    .rf_data_d_in        (rf_data_d_in),
    .query_a             (query_a),
    .query_b             (query_b),
    .hazard_a            (hazard_a),
    .hazard_b            (hazard_b),
    .fwd_a_data          (fwd_a_data),
    .fwd_b_data          (fwd_b_data),
    .pending_count       (pending_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The register file commits whatever is strobed while the port is not stalled.
  always @(posedge clk) begin
    if (rf_write_register_d === 1'b1 && rf_port_stall === 1'b0)
      dut_log.push_back('{addr: rf_register_d, data: rf_data_d_in});
  end

  task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_outputs();
    logic              full;
    logic              exp_ha, exp_hb;
    logic [DATA_W-1:0] exp_fa, exp_fb;
    full   = (model_q.size() == QD);
    exp_ha = 1'b0;
    exp_hb = 1'b0;
    exp_fa = '0;
    exp_fb = '0;
    foreach (model_q[i]) begin
      if (model_q[i].addr == query_a) begin exp_ha = 1'b1; exp_fa = model_q[i].data; end
      if (model_q[i].addr == query_b) begin exp_hb = 1'b1; exp_fb = model_q[i].data; end
    end
`ifndef WB_FORWARD_EN
    exp_fa = '0;
    exp_fb = '0;
`endif
    check("mem_wr_ready", mem_wr_ready, !reset && !full);
    check("alu_wr_ready", alu_wr_ready, !reset && !full && !mem_wr_valid);
    check("strobe", rf_write_register_d, model_q.size() != 0);
    check("rf_register_d", rf_register_d, model_q.size() != 0 ? model_q[0].addr : '0);
    check("rf_data_d_in", rf_data_d_in, model_q.size() != 0 ? model_q[0].data : '0);
    check("pending_count", pending_count, model_q.size());
    check("hazard_a", hazard_a, exp_ha);
    check("hazard_b", hazard_b, exp_hb);
    check("fwd_a_data", fwd_a_data, exp_fa);
    check("fwd_b_data", fwd_b_data, exp_fb);
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the rising edge.
  task automatic tick();
    logic full_pre;
    #1 check_outputs();
    @(posedge clk);
    full_pre = (model_q.size() == QD);
    if (model_q.size() != 0 && !rf_port_stall) exp_log.push_back(model_q[0]);
    if (reset) begin
      model_q.delete();
    end else begin
      if (model_q.size() != 0 && !rf_port_stall) void'(model_q.pop_front());
      if (mem_wr_valid && !full_pre)
        model_q.push_back('{addr: mem_wr_addr, data: mem_wr_data});
      else if (alu_wr_valid && !full_pre)
        model_q.push_back('{addr: alu_wr_addr, data: alu_wr_data});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    rf_port_stall = 1'b0;
    alu_wr_valid  = 1'b0;
    mem_wr_valid  = 1'b0;
    for (int i = 0; i < 20 && model_q.size() != 0; i++) tick();
    tick();
  endtask

  task automatic compare_logs(string tag);
    check({tag, "_nwrites"}, dut_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++) begin
      check({tag, "_waddr"}, dut_log[i].addr, exp_log[i].addr);
      check({tag, "_wdata"}, dut_log[i].data, exp_log[i].data);
    end
    dut_log.delete();
    exp_log.delete();
  endtask

  task automatic alu_req(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    alu_wr_valid = 1'b1;
    alu_wr_addr  = a;
    alu_wr_data  = d;
  endtask

  initial begin
    reset         = 1'b1;
    alu_wr_valid  = 1'b0;
    alu_wr_addr   = '0;
    alu_wr_data   = '0;
    mem_wr_valid  = 1'b0;
    mem_wr_addr   = '0;
    mem_wr_data   = '0;
    rf_port_stall = 1'b0;
    query_a       = '0;
    query_b       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dut_log.delete();

    // Reset state
    #1 check("rst_count", pending_count, 0);
    check("rst_strobe", rf_write_register_d, 0);
    check("rst_ready", {alu_wr_ready, mem_wr_ready}, 2'b11);
    tick();

    // 1: single ALU write
    alu_req(5'd3, 32'hDEAD_BEEF);
    tick();
    alu_wr_valid = 1'b0;
    #1 check("t1_strobe", rf_write_register_d, 1);
    check("t1_rd", rf_register_d, 3);
    check("t1_data", rf_data_d_in, 32'hDEAD_BEEF);
    check("t1_count", pending_count, 1);
    tick();
    check("t1_count_after", pending_count, 0);
    drain();
    check("t1_one_write", dut_log.size(), 1);
    compare_logs("t1");

    // 2: simultaneous load and ALU to the same index
    alu_req(5'd5, 32'd1);
    mem_wr_valid = 1'b1;
    mem_wr_addr  = 5'd5;
    mem_wr_data  = 32'd2;
    #1 check("t2_alu_ready", alu_wr_ready, 0);
    check("t2_mem_ready", mem_wr_ready, 1);
    tick();
    mem_wr_valid = 1'b0;
    tick();
    alu_wr_valid = 1'b0;
    drain();
    check("t2_nwr", dut_log.size(), 2);
    if (dut_log.size() == 2) begin
      check("t2_first", dut_log[0].data, 2);
      check("t2_last", dut_log[1].data, 1);
    end
    compare_logs("t2");

    // 3: stalled port fills the queue
    rf_port_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_req(ADDR_W'(10 + i), $urandom);
      tick();
    end
    alu_wr_valid = 1'b0;
    #1 check("t3_count", pending_count, 4);
    check("t3_ready", {alu_wr_ready, mem_wr_ready}, 2'b00);
    check("t3_held_rd", rf_register_d, 10);
    tick();
    tick();
    check("t3_still_held", rf_register_d, 10);
    drain();
    check("t3_nwr", dut_log.size(), 4);
    compare_logs("t3");

    // 4: hazard and forwarding on a repeated index
    rf_port_stall = 1'b1;
    alu_req(5'd7, 32'h11);
    tick();
    alu_req(5'd7, 32'h22);
    tick();
    alu_wr_valid = 1'b0;
    query_a = 5'd7;
    query_b = 5'd8;
    #1 check("t4_hazard_a", hazard_a, 1);
    check("t4_hazard_b", hazard_b, 0);
`ifdef WB_FORWARD_EN
    check("t4_fwd_a", fwd_a_data, 32'h22);
`else
    check("t4_fwd_a", fwd_a_data, 0);
`endif
    tick();
    drain();
    compare_logs("t4");

    // 5: reset pulse discards a full queue
    rf_port_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_req(ADDR_W'(20 + i), 32'hA0 + 32'(i));
      tick();
    end
    alu_wr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 check("t5_strobe", rf_write_register_d, 0);
    check("t5_count", pending_count, 0);
    check("t5_ready", {alu_wr_ready, mem_wr_ready}, 2'b11);
    drain();
    check("t5_no_writes", dut_log.size(), 0);
    compare_logs("t5");

    // 6: back-to-back writes wrap the pointers
    rf_port_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      alu_req(ADDR_W'(i), DATA_W'(i * 3));
      tick();
    end
    alu_wr_valid = 1'b0;
    drain();
    check("t6_nwr", dut_log.size(), 10);
    if (dut_log.size() == 10) check("t6_last", dut_log[9].data, 27);
    compare_logs("t6");

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      alu_wr_valid  = ($urandom_range(0, 2) != 0);
      alu_wr_addr   = ADDR_W'($urandom_range(0, 7));
      alu_wr_data   = $urandom;
      mem_wr_valid  = ($urandom_range(0, 2) == 0);
      mem_wr_addr   = ADDR_W'($urandom_range(0, 7));
      mem_wr_data   = $urandom;
      rf_port_stall = ($urandom_range(0, 3) == 0);
      query_a       = ADDR_W'($urandom_range(0, 7));
      query_b       = ADDR_W'($urandom_range(0, 7));
      reset         = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    drain();
    compare_logs("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
